// File: rtl/timing_nco.sv
// timing_nco: symbol-timing NCO for the MSK receiver timing-recovery loop.
// A decrementing modulo-2^NCO_W phase accumulator advances once per input
// sample by NOM_STEP + ctrl. An underflow marks the on-time symbol instant
// (strobe_o, mu_o, sym_cnt_o). Falling through the half-scale point marks the
// mid-symbol instant (mid_strobe_o).
// Build option: define TIMING_NCO_CLAMP_EN to clamp ctrl_i at load time to
// +/-(NOM_STEP >> CLAMP_SHIFT).
// Handshake: sample_val_i and ctrl_val_i are single-cycle qualifiers with no
// back-pressure. A sample is consumed in every cycle sample_val_i is high.
// ctrl_i is captured in every cycle ctrl_val_i is high. All outputs are
// registered. Each strobe is a one-cycle pulse in the cycle after its sample.
module timing_nco #(
  parameter int NCO_W       = 24,
  parameter int WERR        = 18,
  parameter int SPS_LOG2    = 2,
  parameter int MU_W        = 16,
  parameter int CLAMP_SHIFT = 6,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_val_i,
  input  logic [WERR-1:0]  ctrl_i,
  input  logic             ctrl_val_i,
  output logic             strobe_o,
  output logic [MU_W-1:0]  mu_o,
  output logic             mid_strobe_o,
  output logic [CNT_W-1:0] sym_cnt_o
);

  // Nominal per-sample phase step (one symbol = 2^SPS_LOG2 steps of full scale).
  localparam logic signed [NCO_W:0] ONE_W     = {{NCO_W{1'b0}}, 1'b1};
  localparam logic signed [NCO_W:0] NOM_STEP  = ONE_W <<< (NCO_W - SPS_LOG2);
  localparam logic signed [NCO_W:0] CLAMP_LIM = NOM_STEP >>> CLAMP_SHIFT;
  localparam logic signed [NCO_W:0] CLAMP_NEG = -CLAMP_LIM;

  // Parameter sanity: these combinations break the step-positivity and
  // no-coincidence arguments the datapath relies on.
  if (SPS_LOG2 < 2) begin : g_chk_sps
    $error("timing_nco: SPS_LOG2 must be >= 2");
  end
  if (WERR - 1 >= NCO_W - SPS_LOG2 - 1) begin : g_chk_werr
    $error("timing_nco: WERR too wide for NCO_W/SPS_LOG2");
  end
  if (MU_W > NCO_W - SPS_LOG2) begin : g_chk_mu
    $error("timing_nco: MU_W exceeds the sub-symbol phase bits");
  end
  if (CLAMP_SHIFT < 0 || CLAMP_SHIFT >= NCO_W - SPS_LOG2) begin : g_chk_clamp
    $error("timing_nco: CLAMP_SHIFT out of range");
  end

  logic        [NCO_W-1:0] nco;
  logic signed [NCO_W:0]   ctrl_reg;
  logic signed [NCO_W:0]   ctrl_ext;
  logic signed [NCO_W:0]   ctrl_load;
  logic signed [NCO_W:0]   step;
  logic signed [NCO_W:0]   nxt;
  logic                    underflow;
  logic                    mid_cross;
  logic                    mu_sat;
  logic        [MU_W-1:0]  mu_bits;

  // Sign-extend the correction and optionally clamp it before it is stored.
  always_comb begin
    ctrl_ext  = {{(NCO_W + 1 - WERR){ctrl_i[WERR-1]}}, ctrl_i};
    ctrl_load = ctrl_ext;
`ifdef TIMING_NCO_CLAMP_EN
    if (ctrl_ext > CLAMP_LIM) begin
      ctrl_load = CLAMP_LIM;
    end else if (ctrl_ext < CLAMP_NEG) begin
      ctrl_load = CLAMP_NEG;
    end
`endif
  end

  // Phase step, next phase and the event decodes derived from them.
  always_comb begin
    step      = NOM_STEP + ctrl_reg;
    nxt       = $signed({1'b0, nco}) - step;
    underflow = nxt[NCO_W];
    // No underflow means nxt >= 0, so nxt < HALF reduces to its top phase bit.
    mid_cross = nco[NCO_W-1] & ~nxt[NCO_W-1];
    // Pre-update phase at or above one nominal step cannot be represented in
    // the sub-symbol fraction; report the largest fraction instead.
    mu_sat    = |nco[NCO_W-1 -: SPS_LOG2];
    mu_bits   = nco[NCO_W-SPS_LOG2-1 -: MU_W];
  end

  // Correction register, phase accumulator and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nco          <= '1;
      ctrl_reg     <= '0;
      strobe_o     <= 1'b0;
      mid_strobe_o <= 1'b0;
      mu_o         <= '0;
      sym_cnt_o    <= '0;
    end else begin
      // A same-cycle sample still sees the old ctrl_reg.
      if (ctrl_val_i) begin
        ctrl_reg <= ctrl_load;
      end
      strobe_o     <= 1'b0;
      mid_strobe_o <= 1'b0;
      if (sample_val_i) begin
        nco <= nxt[NCO_W-1:0];
        if (underflow) begin
          strobe_o  <= 1'b1;
          mu_o      <= mu_sat ? '1 : mu_bits;
          sym_cnt_o <= sym_cnt_o + CNT_W'(1);
        end else begin
          mid_strobe_o <= mid_cross;
        end
      end
    end
  end

endmodule
